// File: rtl/rs_bank_arbiter_pkg.sv
// rs_bank_arbiter_pkg: FSM state encoding and operation codes shared by the RS bank arbiter.
package rs_bank_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_e;
  localparam logic OP_SET = 1'b1;
  localparam logic OP_CLR = 1'b0;
endpackage

// File: rtl/rs_bank_arbiter_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick; lowest requester at or after the pointer wins.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = 1
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [PW-1:0]   ptr_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [PW-1:0]   gidx_o,
  output logic            valid_o
);
  always_comb begin
    gidx_o = '0;
    // Walk from the farthest offset down so the nearest requester is assigned last.
    for (int i = NREQ - 1; i >= 0; i--)
      if (req_i[(int'(ptr_i) + i) % NREQ]) gidx_o = PW'((int'(ptr_i) + i) % NREQ);
    valid_o = |req_i;
    gnt_o   = valid_o ? NREQ'(1) << gidx_o : '0;
  end
endmodule

// File: rtl/rs_bank_arbiter.sv
// rs_bank_arbiter: serialises set/clear requests onto an RS flip-flop bank, never driving R=S=1,
// and confirms each operation through the bank's Q readback before acknowledging.
module rs_bank_arbiter
  import rs_bank_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int NBITS = 8,
  parameter int IDXW  = 3
) (
  input  logic                 C,
  input  logic                 NCLR,
  input  logic [NREQ-1:0]      REQ,
  input  logic [NREQ-1:0]      OP,
  input  logic [NREQ*IDXW-1:0] IDX,
  input  logic [NBITS-1:0]     Q,
  output logic [NBITS-1:0]     R,
  output logic [NBITS-1:0]     S,
  output logic [NREQ-1:0]      ACK,
  output logic                 BUSY,
  output logic                 ERR
);
  localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [PW-1:0]     ptr_q, ptr_d, gnt_q, gnt_d;
  logic              op_q, op_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [NBITS-1:0]  r_q, r_d, s_q, s_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              busy_q, err_q, err_d;
  logic [NREQ-1:0]   arb_gnt;
  logic [PW-1:0]     arb_idx;
  logic              arb_valid;
  logic              req_op;
  logic [IDXW-1:0]   req_idx;
  logic [NBITS-1:0]  req_sel, cur_sel;
  logic              cur_ok, mismatch;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
    .req_i  (REQ),
    .ptr_i  (ptr_q),
    .gnt_o  (arb_gnt),
    .gidx_o (arb_idx),
    .valid_o(arb_valid)
  );

  assign req_op   = |(OP & arb_gnt);
  assign req_idx  = IDX[32'(arb_idx)*IDXW +: IDXW];
  // An out-of-range index shifts the single 1 off the top, so no line is driven.
  assign req_sel  = NBITS'(1) << req_idx;
  assign cur_sel  = NBITS'(1) << idx_q;
  assign cur_ok   = 32'(idx_q) < NBITS;
  assign mismatch = !cur_ok || ((|(Q & cur_sel)) != op_q);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    idx_d   = idx_q;
    r_d     = '0;
    s_d     = '0;
    ack_d   = '0;
    err_d   = err_q;
    case (state_q)
      IDLE: if (arb_valid) begin
        state_d = DRIVE;
        gnt_d   = arb_idx;
        op_d    = req_op;
        idx_d   = req_idx;
        r_d     = req_op == OP_CLR ? req_sel : '0;
        s_d     = req_op == OP_SET ? req_sel : '0;
      end
      DRIVE: state_d = CHECK;
      CHECK: begin
        state_d = DONE;
        ack_d   = NREQ'(1) << gnt_q;
        err_d   = err_q | mismatch;
      end
      DONE: begin
        state_d = IDLE;
        ptr_d   = 32'(gnt_q) == NREQ - 1 ? '0 : gnt_q + PW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge C or negedge NCLR) begin
    if (!NCLR) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_q    <= 1'b0;
      idx_q   <= '0;
      r_q     <= '0;
      s_q     <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      r_q     <= r_d;
      s_q     <= s_d;
      ack_q   <= ack_d;
      busy_q  <= state_d != IDLE;
      err_q   <= err_d;
    end
  end

  assign R    = r_q;
  assign S    = s_q;
  assign ACK  = ack_q;
  assign BUSY = busy_q;
  assign ERR  = err_q;
endmodule

// File: tb/tb_rs_bank_arbiter.sv
// tb_rs_bank_arbiter: directed checks of the RS bank arbiter against a behavioural RS bank.
module tb_rs_bank_arbiter;
  logic       C = 1'b0;
  logic       NCLR;
  logic [1:0] REQ, OP;
  logic [5:0] IDX;
  logic [7:0] Q, R, S, bank, qf_en, qf_val;
  logic [1:0] ACK;
  logic       BUSY, ERR;
  logic [5:0] Q6, R6, S6, bank6;
  logic [1:0] ACK6;
  logic       BUSY6, ERR6;
  int total = 0;
  int bad = 0;

  always #5 C = ~C;

  rs_bank_arbiter #(.NREQ(2), .NBITS(8), .IDXW(3)) dut (
    .C(C), .NCLR(NCLR), .REQ(REQ), .OP(OP), .IDX(IDX), .Q(Q),
    .R(R), .S(S), .ACK(ACK), .BUSY(BUSY), .ERR(ERR)
  );

  rs_bank_arbiter #(.NREQ(2), .NBITS(6), .IDXW(3)) dut6 (
    .C(C), .NCLR(NCLR), .REQ(REQ), .OP(OP), .IDX(IDX), .Q(Q6),
    .R(R6), .S(S6), .ACK(ACK6), .BUSY(BUSY6), .ERR(ERR6)
  );

  // Behavioural RS bank: set wins nothing, the DUT never drives both.
  always @(posedge C or negedge NCLR)
    if (!NCLR) begin
      bank  <= '0;
      bank6 <= '0;
    end else begin
      bank  <= (bank & ~R) | S;
      bank6 <= (bank6 & ~R6) | S6;
    end

  assign Q  = (bank & ~qf_en) | (qf_val & qf_en);
  assign Q6 = bank6;

  task automatic apply_reset;
    NCLR = 1'b0;
    REQ = '0; OP = '0; IDX = '0;
    @(negedge C);
    @(negedge C);
    NCLR = 1'b1;
  endtask

  task automatic test_reset;
    logic seen_ack;
    qf_en = '0; qf_val = '0;
    apply_reset();
    @(negedge C);
    total++; if (R !== 8'h00) begin bad++; $display("FAIL reset_R got=%h exp=00", R); end
    total++; if (S !== 8'h00) begin bad++; $display("FAIL reset_S got=%h exp=00", S); end
    total++; if (ACK !== 2'b00) begin bad++; $display("FAIL reset_ACK got=%b exp=00", ACK); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL reset_BUSY got=%b exp=0", BUSY); end
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL reset_ERR got=%b exp=0", ERR); end
    REQ = 2'b01; OP = 2'b01; IDX = {3'd0, 3'd3};
    @(negedge C);
    REQ = 2'b00;
    total++; if (S !== 8'h08) begin bad++; $display("FAIL abort_S_before got=%h exp=08", S); end
    #2 NCLR = 1'b0;
    #1;
    total++; if (S !== 8'h00 || R !== 8'h00) begin bad++; $display("FAIL abort_RS got=%h/%h exp=00/00", R, S); end
    total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL abort_BUSY got=%b exp=0", BUSY); end
    @(negedge C);
    NCLR = 1'b1;
    seen_ack = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge C);
      seen_ack = seen_ack | (|ACK);
    end
    total++; if (seen_ack !== 1'b0) begin bad++; $display("FAIL abort_no_ack got=%b exp=0", seen_ack); end
  endtask

  task automatic test_set_clear;
    apply_reset();
    REQ = 2'b01; OP = 2'b01; IDX = {3'd0, 3'd5};
    @(negedge C);
    REQ = 2'b00;
    total++; if (S !== 8'h20 || R !== 8'h00) begin bad++; $display("FAIL set_drive got=%h/%h exp=00/20", R, S); end
    total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL set_busy got=%b exp=1", BUSY); end
    @(negedge C);
    total++; if (S !== 8'h00) begin bad++; $display("FAIL set_release got=%h exp=00", S); end
    total++; if (Q[5] !== 1'b1) begin bad++; $display("FAIL set_q5 got=%b exp=1", Q[5]); end
    @(negedge C);
    total++; if (ACK !== 2'b01) begin bad++; $display("FAIL set_ack got=%b exp=01", ACK); end
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL set_err got=%b exp=0", ERR); end
    @(negedge C);
    total++; if (ACK !== 2'b00 || BUSY !== 1'b0) begin bad++; $display("FAIL set_idle got=%b/%b exp=00/0", ACK, BUSY); end
    REQ = 2'b01; OP = 2'b00; IDX = {3'd0, 3'd5};
    @(negedge C);
    REQ = 2'b00;
    total++; if (R !== 8'h20 || S !== 8'h00) begin bad++; $display("FAIL clr_drive got=%h/%h exp=20/00", R, S); end
    @(negedge C);
    total++; if (R !== 8'h00 || Q[5] !== 1'b0) begin bad++; $display("FAIL clr_q5 got=%h/%b exp=00/0", R, Q[5]); end
    @(negedge C);
    total++; if (ACK !== 2'b01 || ERR !== 1'b0) begin bad++; $display("FAIL clr_ack got=%b/%b exp=01/0", ACK, ERR); end
    @(negedge C);
  endtask

  task automatic test_round_robin;
    logic [1:0] exp_ack;
    logic [15:0] exp_rs;
    apply_reset();
    REQ = 2'b11; OP = 2'b10; IDX = {3'd4, 3'd1};
    for (int j = 0; j < 16; j++) begin
      @(negedge C);
      exp_ack = (j % 8 == 2) ? 2'b01 : (j % 8 == 6) ? 2'b10 : 2'b00;
      exp_rs  = (j % 8 == 0) ? 16'h0200 : (j % 8 == 4) ? 16'h0010 : 16'h0000;
      total++; if (ACK !== exp_ack) begin bad++; $display("FAIL rr_ack[%0d] got=%b exp=%b", j, ACK, exp_ack); end
      total++; if ({R, S} !== exp_rs) begin bad++; $display("FAIL rr_rs[%0d] got=%h exp=%h", j, {R, S}, exp_rs); end
      total++; if ((R & S) !== 8'h00) begin bad++; $display("FAIL rr_overlap[%0d] got=%h exp=00", j, R & S); end
    end
    REQ = 2'b00;
    @(negedge C);
    total++; if (ERR !== 1'b0 || BUSY !== 1'b0) begin bad++; $display("FAIL rr_end got=%b/%b exp=0/0", ERR, BUSY); end
  endtask

  task automatic test_readback_error;
    apply_reset();
    qf_en = 8'h04; qf_val = 8'h00;
    REQ = 2'b10; OP = 2'b10; IDX = {3'd2, 3'd0};
    @(negedge C);
    REQ = 2'b00;
    total++; if (S !== 8'h04) begin bad++; $display("FAIL rb_drive got=%h exp=04", S); end
    @(negedge C);
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL rb_err_early got=%b exp=0", ERR); end
    @(negedge C);
    total++; if (ACK !== 2'b10) begin bad++; $display("FAIL rb_ack got=%b exp=10", ACK); end
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL rb_err got=%b exp=1", ERR); end
    REQ = 2'b01; OP = 2'b01; IDX = {3'd0, 3'd6};
    @(negedge C);
    @(negedge C);
    REQ = 2'b00;
    repeat (4) @(negedge C);
    total++; if (Q[6] !== 1'b1) begin bad++; $display("FAIL rb_good_op got=%b exp=1", Q[6]); end
    total++; if (ERR !== 1'b1) begin bad++; $display("FAIL rb_sticky got=%b exp=1", ERR); end
    qf_en = '0;
    apply_reset();
    @(negedge C);
    total++; if (ERR !== 1'b0) begin bad++; $display("FAIL rb_cleared got=%b exp=0", ERR); end
  endtask

  task automatic test_bad_index;
    apply_reset();
    REQ = 2'b01; OP = 2'b01; IDX = {3'd0, 3'd7};
    @(negedge C);
    REQ = 2'b00;
    total++; if (BUSY6 !== 1'b1) begin bad++; $display("FAIL bi_busy got=%b exp=1", BUSY6); end
    for (int j = 0; j < 4; j++) begin
      total++; if ({R6, S6} !== 12'h000) begin bad++; $display("FAIL bi_rs[%0d] got=%h exp=000", j, {R6, S6}); end
      if (j == 2) begin
        total++; if (ACK6 !== 2'b01) begin bad++; $display("FAIL bi_ack got=%b exp=01", ACK6); end
        total++; if (ERR6 !== 1'b1) begin bad++; $display("FAIL bi_err got=%b exp=1", ERR6); end
      end
      @(negedge C);
    end
  endtask

  task automatic test_drop_req;
    apply_reset();
    REQ = 2'b01; OP = 2'b01; IDX = {3'd0, 3'd3};
    @(negedge C);
    REQ = 2'b00; OP = 2'b00; IDX = {3'd0, 3'd6};
    total++; if (S !== 8'h08 || R !== 8'h00) begin bad++; $display("FAIL drop_drive got=%h/%h exp=00/08", R, S); end
    @(negedge C);
    total++; if (Q[3] !== 1'b1 || {R, S} !== 16'h0000) begin bad++; $display("FAIL drop_q3 got=%b/%h exp=1/0000", Q[3], {R, S}); end
    @(negedge C);
    total++; if (ACK !== 2'b01 || ERR !== 1'b0) begin bad++; $display("FAIL drop_ack got=%b/%b exp=01/0", ACK, ERR); end
    @(negedge C);
    @(negedge C);
    total++; if (BUSY !== 1'b0 || ACK !== 2'b00) begin bad++; $display("FAIL drop_idle got=%b/%b exp=0/00", BUSY, ACK); end
  endtask

  initial begin
    test_reset();
    test_set_clear();
    test_round_robin();
    test_readback_error();
    test_bad_index();
    test_drop_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
